// File: rtl/w1_fetch.sv
// w1_fetch: streams KSIZE conv1 kernel taps from six shared-address weight ROMs.
// Latency: with w_ready high, first w_valid 3 cycles after the start cycle, then one tap per cycle.
// Backpressure: a 2-entry skid FIFO plus one read in flight; address issue stalls so the FIFO never overflows.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   start / busy / done      run request, run-in-progress flag, one-cycle completion pulse
//   w1_raddr                 shared ROM address (driven in the issue cycle, holds otherwise)
//   w1_1_rdata..w1_6_rdata   registered ROM data, valid one cycle after the address
//   w_valid / w_ready        weight word handshake
//   w_data / w_idx / w_last  {w1_6..w1_1} for one tap, its index, last-tap flag
module w1_fetch #(
  parameter int KSIZE = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  w1_raddr,
  input  logic [7:0]  w1_1_rdata,
  input  logic [7:0]  w1_2_rdata,
  input  logic [7:0]  w1_3_rdata,
  input  logic [7:0]  w1_4_rdata,
  input  logic [7:0]  w1_5_rdata,
  input  logic [7:0]  w1_6_rdata,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [47:0] w_data,
  output logic [4:0]  w_idx,
  output logic        w_last
);

  localparam logic [4:0] LAST_IDX = 5'(KSIZE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t      state;
  logic [4:0]  cnt;        // next tap address to issue
  logic [4:0]  raddr_q;    // last issued address; also the tag of the read in flight
  logic        inflight;   // an address was issued last cycle, data lands this cycle

  logic [47:0] fifo_dat [2];
  logic [4:0]  fifo_idx [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;

  assign pop  = w_valid & w_ready;
  assign push = inflight;

  // Entries that will be held once everything already requested has landed.
  // pop implies fifo_count >= 1, so this never goes negative.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == FETCH) && (occupancy < 3'd2);

  // The address goes out in the issue cycle so the registered ROM answers in
  // the very next cycle, which is when the FIFO write happens.
  assign w1_raddr = issue ? cnt : raddr_q;

  assign w_valid = (fifo_count != 2'd0);
  assign w_data  = fifo_dat[rd_ptr];
  assign w_idx   = fifo_idx[rd_ptr];
  assign w_last  = w_valid && (fifo_idx[rd_ptr] == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      raddr_q     <= 5'd0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      fifo_dat[0] <= 48'd0;
      fifo_dat[1] <= 48'd0;
      fifo_idx[0] <= 5'd0;
      fifo_idx[1] <= 5'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;

      if (issue) begin
        cnt     <= cnt + 5'd1;
        raddr_q <= cnt;
      end

      if (push) begin
        fifo_dat[wr_ptr] <= {w1_6_rdata, w1_5_rdata, w1_4_rdata,
                             w1_3_rdata, w1_2_rdata, w1_1_rdata};
        fifo_idx[wr_ptr] <= raddr_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= 5'd0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (issue && (cnt == LAST_IDX)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last tap can only be popped here: its data lands in the
          // first DRAIN cycle at the earliest.
          if (pop && w_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w1_fetch.sv
module tb_w1_fetch;

  localparam int K = 25;

  logic        clk = 1'b0;
  logic        rst, start, w_ready;
  logic        busy, done, w_valid, w_last;
  logic [4:0]  w1_raddr, w_idx;
  logic [47:0] w_data;
  logic [7:0]  r1, r2, r3, r4, r5, r6;

  // KSIZE=1 instance
  logic        start1, ready1;
  logic        busy1, done1, valid1, last1;
  logic [4:0]  raddr1, idx1;
  logic [47:0] data1;
  logic [7:0]  q1, q2, q3, q4, q5, q6;

  always #5 clk = ~clk;

  w1_fetch #(.KSIZE(K)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w1_raddr(w1_raddr),
    .w1_1_rdata(r1), .w1_2_rdata(r2), .w1_3_rdata(r3),
    .w1_4_rdata(r4), .w1_5_rdata(r5), .w1_6_rdata(r6),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_idx(w_idx), .w_last(w_last)
  );

  w1_fetch #(.KSIZE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .w1_raddr(raddr1),
    .w1_1_rdata(q1), .w1_2_rdata(q2), .w1_3_rdata(q3),
    .w1_4_rdata(q4), .w1_5_rdata(q5), .w1_6_rdata(q6),
    .w_valid(valid1), .w_ready(ready1), .w_data(data1),
    .w_idx(idx1), .w_last(last1)
  );

  // Registered ROM models: ROM j returns {j, address} so lane order is visible.
  always @(posedge clk) begin
    r1 <= {3'd1, w1_raddr}; r2 <= {3'd2, w1_raddr}; r3 <= {3'd3, w1_raddr};
    r4 <= {3'd4, w1_raddr}; r5 <= {3'd5, w1_raddr}; r6 <= {3'd6, w1_raddr};
    q1 <= {3'd1, raddr1};   q2 <= {3'd2, raddr1};   q3 <= {3'd3, raddr1};
    q4 <= {3'd4, raddr1};   q5 <= {3'd5, raddr1};   q6 <= {3'd6, raddr1};
  end

  function automatic logic [47:0] word(input logic [4:0] k);
    return {3'd6, k, 3'd5, k, 3'd4, k, 3'd3, k, 3'd2, k, 3'd1, k};
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int          cyc_no = 0;
  int          exp_idx = 0;
  int          ntrans = 0;
  int          ndone = 0;
  bit          busy_exp = 0;
  bit          done_exp = 0;
  bit          post_rst = 0;
  bit          stalled_prev = 0;
  logic [4:0]  prev_idx;
  logic [47:0] prev_data;
  bit          took;
  bit          done_seen;

  // One clock cycle: drive inputs at the falling edge, check the cycle's outputs,
  // then advance the expected protocol state.
  task automatic cyc(input logic st, input logic rdy, input logic r);
    bit last_now;
    @(negedge clk);
    start = st; w_ready = rdy; rst = r;
    #1;
    cyc_no++;
    took = 1'b0;
    last_now = 1'b0;
    done_seen = 1'b0;
    if (post_rst) begin
      chk("rst_raddr", 64'(w1_raddr), 64'd0);
      chk("rst_valid", 64'(w_valid), 64'd0);
      chk("rst_data",  64'(w_data),  64'd0);
      chk("rst_idx",   64'(w_idx),   64'd0);
      chk("rst_last",  64'(w_last),  64'd0);
      chk("rst_busy",  64'(busy),    64'd0);
      chk("rst_done",  64'(done),    64'd0);
    end else begin
      chk("busy", 64'(busy), 64'(busy_exp));
      chk("done", 64'(done), 64'(done_exp));
      if (done) begin
        ndone++;
        done_seen = 1'b1;
      end
      if (stalled_prev) begin
        chk("hold_valid", 64'(w_valid), 64'd1);
        chk("hold_idx",   64'(w_idx),   64'(prev_idx));
        chk("hold_data",  64'(w_data),  64'(prev_data));
      end
      if (w_valid && rdy && !r) begin
        took = 1'b1;
        last_now = (exp_idx == K - 1);
        chk("xfer_idx",  64'(w_idx),  64'(exp_idx));
        chk("xfer_data", 64'(w_data), 64'(word(5'(exp_idx))));
        chk("xfer_last", 64'(w_last), 64'(last_now));
        exp_idx++;
        ntrans++;
      end
    end
    done_exp     = !r && last_now;
    stalled_prev = !r && w_valid && !rdy;
    prev_idx     = w_idx;
    prev_data    = w_data;
    if (r) begin
      busy_exp = 1'b0;
      exp_idx  = 0;
    end else if (!busy_exp && st) begin
      busy_exp = 1'b1;
      exp_idx  = 0;
      ntrans   = 0;
      ndone    = 0;
    end else if (last_now) begin
      busy_exp = 1'b0;
    end
    post_rst = r;
  endtask

  // mode 0: full rate, 1: stall window, 2: random ready,
  // 3: random ready with start pulsed while busy, 4: reset after idx 10
  task automatic run(input int mode);
    int first_c, last_c;
    bit finished;
    first_c = -1; last_c = -1; finished = 0;
    cyc(1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 400; c++) begin
      logic rdy, st;
      case (mode)
        0, 4:    rdy = 1'b1;
        1:       rdy = !(c >= 4 && c <= 10);
        default: rdy = 1'($urandom % 2);
      endcase
      st = (mode == 3) && (c % 5 == 2) && (c < 30);
      cyc(st, rdy, 1'b0);
      if (took) begin
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (mode == 1 && c >= 5 && c <= 10) begin
        chk("bp_valid", 64'(w_valid),  64'd1);
        chk("bp_idx",   64'(w_idx),    64'd1);
        chk("bp_raddr", 64'(w1_raddr), 64'd2);
      end
      if (mode == 4 && exp_idx == 11) begin
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        finished = 1;
        break;
      end
      if (done_seen) begin
        if (mode == 0) begin
          chk("fr_first", 64'(first_c), 64'd3);
          chk("fr_lastc", 64'(last_c),  64'(K + 2));
          chk("fr_donec", 64'(c),       64'(K + 3));
        end
        finished = 1;
        break;
      end
    end
    chk("run_finished", 64'(finished), 64'd1);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    if (mode == 4) begin
      chk("abort_ndone", 64'(ndone), 64'd0);
    end else begin
      chk("run_ntrans", 64'(ntrans), 64'(K));
      chk("run_ndone",  64'(ndone),  64'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; w_ready = 1'b0;
    start1 = 1'b0; ready1 = 1'b1;
    repeat (2) @(negedge clk);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);          // reset-state checks

    run(0);
    run(1);
    for (int i = 0; i < 20; i++) run(2);
    run(3);
    run(4);
    run(0);

    // start together with rst must not begin a run
    cyc(1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);

    // KSIZE=1 instance
    begin
      int vc;
      vc = -1;
      @(negedge clk);
      start1 = 1'b1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        start1 = 1'b0;
        #1;
        if (valid1) begin
          vc = c;
          chk("k1_idx",  64'(idx1),  64'd0);
          chk("k1_last", 64'(last1), 64'd1);
          chk("k1_data", 64'(data1), 64'(word(5'd0)));
          break;
        end
      end
      chk("k1_first", 64'(vc), 64'd3);
      @(negedge clk);
      #1;
      chk("k1_done",  64'(done1),  64'd1);
      chk("k1_busy",  64'(busy1),  64'd0);
      chk("k1_empty", 64'(valid1), 64'd0);
      @(negedge clk);
      #1;
      chk("k1_done_pulse", 64'(done1), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
